// File: rtl/n64_send_response_if.sv
// Request and line signals of the N64 response transmitter.
// master = controller logic plus line model, slave = the transmitter.
interface n64_send_response_if;
  // Handshake: start is a one-cycle request. It is accepted only on a cycle where busy=0 and
  // num_bytes is 1..4. Exactly one of done or collision ends every accepted request, as a
  // one-cycle pulse on the same cycle that busy falls.
  logic        start;
  logic [31:0] data_in;
  logic [2:0]  num_bytes;
  logic        n64d;
  logic        n64d_oe;
  logic        busy;
  logic        done;
  logic        collision;

  modport master (
    output start, data_in, num_bytes, n64d,
    input  n64d_oe, busy, done, collision
  );

  modport slave (
    input  start, data_in, num_bytes, n64d,
    output n64d_oe, busy, done, collision
  );
endinterface

// File: rtl/n64_send_response.sv
// Controller-side N64 transmitter: turnaround gap, pulse-width coded bytes MSB-first,
// 2 us stop bit, then a recovery window. The line is released and monitored for collisions.
module n64_send_response #(
  parameter int ONE_US     = 50,
  parameter int TWO_US     = 100,
  parameter int THREE_US   = 150,
  parameter int TURNAROUND = 100,
  parameter int SETTLE     = 10
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  n64_send_response_if.slave         bus,
  output logic [2:0]                 state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DELAY    = 3'd1,
    S_LOW      = 3'd2,
    S_HIGH     = 3'd3,
    S_STOP_LOW = 3'd4,
    S_RECOVER  = 3'd5
  } state_t;

  // Phase timer counts up from 0; each phase ends on the cycle its count equals length-1.
  localparam logic [7:0] ONE_LAST   = 8'(ONE_US - 1);
  localparam logic [7:0] TWO_LAST   = 8'(TWO_US - 1);
  localparam logic [7:0] THREE_LAST = 8'(THREE_US - 1);
  localparam logic [7:0] TURN_LAST  = 8'(TURNAROUND - 1);
  localparam logic [7:0] SETTLE_C   = 8'(SETTLE);

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  bits_q, bits_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        coll_q, coll_d;
  logic        sync1_q, sync2_q;

  logic [7:0]  low_last;
  logic [7:0]  high_last;
  logic        len_ok;
  logic        line_low_checked;

  // A '1' bit is short low / long high; a '0' bit is the reverse.
  assign low_last  = shift_q[31] ? ONE_LAST : THREE_LAST;
  assign high_last = shift_q[31] ? THREE_LAST : ONE_LAST;
  assign len_ok    = (bus.num_bytes != 3'd0) && (bus.num_bytes <= 3'd4);
  assign line_low_checked = !sync2_q && (phase_q >= SETTLE_C);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 8'd1;
    shift_d = shift_q;
    bits_d  = bits_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    coll_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        phase_d = 8'd0;
        if (bus.start && len_ok) begin
          shift_d = bus.data_in;
          bits_d  = {bus.num_bytes, 3'b000};
          busy_d  = 1'b1;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (phase_q == TURN_LAST) begin
          phase_d = 8'd0;
          oe_d    = 1'b1;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (phase_q == low_last) begin
          phase_d = 8'd0;
          oe_d    = 1'b0;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (line_low_checked) begin
          coll_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (phase_q == high_last) begin
          phase_d = 8'd0;
          shift_d = {shift_q[30:0], 1'b0};
          bits_d  = bits_q - 6'd1;
          oe_d    = 1'b1;
          state_d = (bits_q == 6'd1) ? S_STOP_LOW : S_LOW;
        end
      end
      S_STOP_LOW: begin
        if (phase_q == TWO_LAST) begin
          phase_d = 8'd0;
          oe_d    = 1'b0;
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        // A collision in the last recovery cycle still wins over completion.
        if (line_low_checked) begin
          coll_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (phase_q == ONE_LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        oe_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      phase_q <= 8'd0;
      shift_q <= 32'd0;
      bits_q  <= 6'd0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      coll_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      shift_q <= shift_d;
      bits_q  <= bits_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      coll_q  <= coll_d;
      sync1_q <= bus.n64d;
      sync2_q <= sync1_q;
    end
  end

  assign bus.n64d_oe   = oe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.collision = coll_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_n64_send_response.sv
// Bench for n64_send_response: a per-cycle timeline model of the line and status outputs,
// built from bit timing rules, compared against the DUT every cycle.
module tb_n64_send_response;

  localparam int T_ONE    = 50;
  localparam int T_TWO    = 100;
  localparam int T_THREE  = 150;
  localparam int T_TURN   = 100;
  localparam int T_SETTLE = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pull_low = 1'b0;
  logic       glitch_low = 1'b0;
  logic       glitch_en = 1'b0;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;

  // Entry per cycle: {chk, oe, busy, done, coll}; chk marks cycles where a low line is a collision.
  logic [4:0] exp_q[$];

  n64_send_response_if bus();

  assign bus.n64d = ~(bus.n64d_oe | pull_low | glitch_low);

  n64_send_response dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic void push_frame(input logic [31:0] d, input int nb);
    logic bit_v;
    int lo;
    for (int i = 0; i < T_TURN; i++) exp_q.push_back(5'b00100);
    for (int b = 0; b < 8 * nb; b++) begin
      bit_v = d[31 - b];
      lo = bit_v ? T_ONE : T_THREE;
      for (int i = 0; i < lo; i++) exp_q.push_back(5'b01100);
      for (int i = 0; i < (T_ONE + T_THREE) - lo; i++)
        exp_q.push_back((i >= T_SETTLE) ? 5'b10100 : 5'b00100);
    end
    for (int i = 0; i < T_TWO; i++) exp_q.push_back(5'b01100);
    for (int i = 0; i < T_ONE; i++)
      exp_q.push_back((i >= T_SETTLE) ? 5'b10100 : 5'b00100);
    exp_q.push_back(5'b00010);
  endfunction

  // Line held low from the current cycle (queue entry 0) on; two synchroniser cycles later the
  // first checked cycle detects it and the next cycle shows the collision pulse.
  function automatic void inject_collision();
    logic [4:0] e;
    for (int i = 2; i < exp_q.size(); i++) begin
      e = exp_q[i];
      if (e[4]) begin
        while (exp_q.size() > i + 1) void'(exp_q.pop_back());
        exp_q.push_back(5'b00001);
        return;
      end
    end
  endfunction

  // ---------------- scoreboard compare ----------------
  logic [4:0] cmp_e;
  logic [3:0] cmp_a;
  always @(negedge clk) begin
    cmp_e = 5'd0;
    if (exp_q.size() > 0) cmp_e = exp_q.pop_front();
    cmp_a = {bus.n64d_oe, bus.busy, bus.done, bus.collision};
    checks++;
    if (cmp_a !== cmp_e[3:0]) begin
      failures++;
      $display("FAIL out_cmp t=%0t {oe,busy,done,coll} act=%b exp=%b", $time, cmp_a, cmp_e[3:0]);
    end
  end

  // Line bully: pulls the line low for the first 5 cycles after every release.
  initial begin : bully
    logic prev_oe;
    int cnt;
    prev_oe = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (glitch_en && prev_oe && !bus.n64d_oe) cnt = 5;
      glitch_low = (cnt > 0);
      if (cnt > 0) cnt--;
      prev_oe = bus.n64d_oe;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] d, input logic [2:0] nb);
    logic       acc;
    logic [4:0] e;
    bus.data_in   = d;
    bus.num_bytes = nb;
    bus.start     = 1'b1;
    acc = (nb >= 3'd1) && (nb <= 3'd4);
    if (exp_q.size() > 1) acc = 1'b0;
    else if (exp_q.size() == 1) begin
      e = exp_q[0];
      if (e[2]) acc = 1'b0;
    end
    @(posedge clk);
    if (acc) push_frame(d, int'(nb));
    #1;
    bus.start     = 1'b0;
    bus.data_in   = $urandom;
    bus.num_bytes = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20000) begin
      wait_cycle();
      n++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL wait_idle timeout act=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
    wait_cycle();
  endtask

  task automatic measure_frame(input logic [31:0] d, input logic [2:0] nb,
                               output int first_oe, output int done_at,
                               output int busy_cnt, output int coll_cnt);
    pulse_start(d, nb);
    first_oe = -1;
    done_at  = -1;
    busy_cnt = 0;
    coll_cnt = 0;
    for (int c = 1; c < 8000 && done_at < 0; c++) begin
      if (bus.n64d_oe && first_oe < 0) first_oe = c;
      if (bus.busy) busy_cnt++;
      if (bus.collision) coll_cnt++;
      if (bus.done) done_at = c;
      wait_cycle();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [4:0] e;
    int first_oe, done_at, busy_cnt, coll_cnt, lat, done_cnt, k, v, nb;
    logic [31:0] d;

    bus.start = 1'b0;
    bus.data_in = 32'd0;
    bus.num_bytes = 3'd0;

    // Pin the model with hand-computed points of the 0x05 single-byte frame.
    push_frame(32'h05000000, 1);
    check("model_len", exp_q.size(), 1851);
    e = exp_q[99];   check("model_c100_oe", int'(e[3]), 0);
    e = exp_q[100];  check("model_c101_oe", int'(e[3]), 1);
    e = exp_q[249];  check("model_c250_oe", int'(e[3]), 1);
    e = exp_q[250];  check("model_c251_oe", int'(e[3]), 0);
    e = exp_q[1549]; check("model_c1550_oe", int'(e[3]), 1);
    e = exp_q[1550]; check("model_c1551_oe", int'(e[3]), 0);
    e = exp_q[1849]; check("model_c1850_busy", int'(e[2]), 1);
    e = exp_q[1850]; check("model_c1851_done", int'(e), 2);
    exp_q.delete();

    #2 rst_n = 1'b0;
    repeat (3) wait_cycle();
    check("reset_oe", int'(bus.n64d_oe), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_coll", int'(bus.collision), 0);
    rst_n = 1'b1;
    repeat (3) wait_cycle();

    // 1: single byte 0x05
    measure_frame(32'h05A1B2C3, 3'd1, first_oe, done_at, busy_cnt, coll_cnt);
    check("t1_first_low", first_oe, 101);
    check("t1_done_cycle", done_at, 1851);
    check("t1_busy_cycles", busy_cnt, 1850);
    check("t1_coll", coll_cnt, 0);
    wait_idle();

    // 2: four bytes 0xFF00A55A
    measure_frame(32'hFF00A55A, 3'd4, first_oe, done_at, busy_cnt, coll_cnt);
    check("t2_first_low", first_oe, 101);
    check("t2_done_cycle", done_at, 6651);
    check("t2_busy_cycles", busy_cnt, 6650);
    wait_idle();

    // 3: illegal lengths, then a start during a busy transfer
    pulse_start(32'h12345678, 3'd0);
    repeat (3) wait_cycle();
    pulse_start(32'h12345678, 3'd5);
    repeat (3) wait_cycle();
    check("t3_busy", int'(bus.busy), 0);
    pulse_start(32'h96000000, 3'd1);
    repeat (300) wait_cycle();
    pulse_start(32'hFFFFFFFF, 3'd4);
    wait_idle();

    // 4: collision in HIGH of bit 3 (a '0' bit: HIGH starts at cycle 851), 20th cycle = 870
    pulse_start(32'hA5000000, 3'd2);
    repeat (869) wait_cycle();
    pull_low = 1'b1;
    inject_collision();
    lat = -1;
    done_cnt = 0;
    for (int j = 0; j < 6; j++) begin
      if (bus.collision && lat < 0) begin
        lat = j;
        check("t4_oe_at_coll", int'(bus.n64d_oe), 0);
        check("t4_busy_at_coll", int'(bus.busy), 0);
      end
      wait_cycle();
    end
    check("t4_coll_within_3", int'(lat >= 1 && lat <= 3), 1);
    for (int j = 0; j < 1200; j++) begin
      if (bus.done) done_cnt++;
      wait_cycle();
    end
    check("t4_no_done", done_cnt, 0);
    pull_low = 1'b0;
    wait_idle();
    measure_frame(32'h3C000000, 3'd1, first_oe, done_at, busy_cnt, coll_cnt);
    check("t4_next_done", done_at, 1851);
    wait_idle();

    // 5: reset in the middle of a LOW phase
    pulse_start(32'h3C000000, 3'd1);
    repeat (110) wait_cycle();
    check("t5_oe_before_rst", int'(bus.n64d_oe), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_oe_async", int'(bus.n64d_oe), 0);
    check("t5_busy_rst", int'(bus.busy), 0);
    check("t5_done_rst", int'(bus.done), 0);
    check("t5_coll_rst", int'(bus.collision), 0);
    repeat (3) wait_cycle();
    rst_n = 1'b1;
    repeat (2) wait_cycle();
    measure_frame(32'hC3000000, 3'd1, first_oe, done_at, busy_cnt, coll_cnt);
    check("t5_after_rst_done", done_at, 1851);
    wait_idle();

    // 6: short pulls right after each release must be masked
    glitch_en = 1'b1;
    measure_frame(32'h5AC30000, 3'd2, first_oe, done_at, busy_cnt, coll_cnt);
    check("t6_done_cycle", done_at, 3451);
    check("t6_no_coll", coll_cnt, 0);
    wait_idle();
    glitch_en = 1'b0;
    repeat (6) wait_cycle();

    // Randomized frames, illegal starts, starts while busy and collisions
    for (int it = 0; it < 4; it++) begin
      repeat ($urandom_range(0, 20)) wait_cycle();
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom_range(0, 3);
        pulse_start($urandom, (v == 0) ? 3'd0 : 3'(v + 4));
      end
      d  = $urandom;
      nb = $urandom_range(1, 4);
      pulse_start(d, 3'(nb));
      k = $urandom_range(20, 200 * 8 * nb + 100);
      repeat (k) wait_cycle();
      if ($urandom_range(0, 2) == 0) begin
        pull_low = 1'b1;
        inject_collision();
      end else begin
        pulse_start($urandom, 3'($urandom_range(1, 4)));
      end
      wait_idle();
      pull_low = 1'b0;
      repeat (3) wait_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
